// File: rtl/key_mode_sel_if.sv
// Key/mode bus between the debounced push-button selector and its user.
// The master drives the raw key; the slave returns the debounced flag, level and mode.
interface key_mode_sel_if;
   logic       key_in;
   logic       key_flag;
   logic       key_state;
   logic [1:0] mode;

   modport master (
      output key_in,
      input  key_flag,
      input  key_state,
      input  mode
   );

   modport slave (
      input  key_in,
      output key_flag,
      output key_state,
      output mode
   );
endinterface

// File: rtl/key_mode_sel.sv
// Push-button debouncer with press/release filter FSM and a wrapping LED mode counter.
// A press is confirmed after CNT_MAX stable cycles; each confirmed press steps the mode.
module key_mode_sel #(
   parameter int CNT_MAX  = 1_000_000,
   parameter int MODE_NUM = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   key_mode_sel_if.slave  kbus
);

   localparam int               CNT_W     = $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CNT_MAX - 1);
   localparam logic [1:0]       MODE_LAST = 2'(MODE_NUM - 1);

   typedef enum logic [1:0] {
      IDLE,
      FILTER_DOWN,
      DOWN,
      FILTER_UP
   } state_t;

   state_t           state_reg, state_next;
   logic             k1_reg, k2_reg, k3_reg;
   logic             neg_edge, pos_edge;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             key_flag_reg, key_flag_next;
   logic             key_state_reg, key_state_next;
   logic [1:0]       mode_reg, mode_next;

   // Reset value 1 means a key already held low at reset release yields a neg_edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         k1_reg <= 1'b1;
         k2_reg <= 1'b1;
         k3_reg <= 1'b1;
      end else begin
         k1_reg <= kbus.key_in;
         k2_reg <= k1_reg;
         k3_reg <= k2_reg;
      end
   end

   assign neg_edge = k3_reg & ~k2_reg;
   assign pos_edge = ~k3_reg & k2_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         key_flag_reg  <= 1'b0;
         key_state_reg <= 1'b1;
         mode_reg      <= 2'd0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         key_flag_reg  <= key_flag_next;
         key_state_reg <= key_state_next;
         mode_reg      <= mode_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      key_flag_next  = 1'b0;
      key_state_next = key_state_reg;
      mode_next      = mode_reg;
      case (state_reg)
         IDLE: begin
            if (neg_edge) begin
               state_next = FILTER_DOWN;
               cnt_next   = '0;
            end
         end
         FILTER_DOWN: begin
            // A bounce back up takes priority over the window expiring.
            if (pos_edge) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
               state_next     = DOWN;
               cnt_next       = '0;
               key_flag_next  = 1'b1;
               key_state_next = 1'b0;
               mode_next      = (mode_reg == MODE_LAST) ? 2'd0 : mode_reg + 2'd1;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         DOWN: begin
            if (pos_edge) begin
               state_next = FILTER_UP;
               cnt_next   = '0;
            end
         end
         FILTER_UP: begin
            if (neg_edge) begin
               state_next = DOWN;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
               state_next     = IDLE;
               cnt_next       = '0;
               key_state_next = 1'b1;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   assign kbus.key_flag  = key_flag_reg;
   assign kbus.key_state = key_state_reg;
   assign kbus.mode      = mode_reg;

endmodule

// File: tb/tb_key_mode_sel.sv
// Bench for key_mode_sel: run-length reference model checked every cycle,
// directed press/bounce/wrap/reset scenarios with literal latencies, then random key activity.
module tb_key_mode_sel;

   localparam int CNT_MAX  = 10;
   localparam int MODE_NUM = 4;

   logic clk;
   logic rst_n;
   key_mode_sel_if bus ();

   key_mode_sel #(
      .CNT_MAX  (CNT_MAX),
      .MODE_NUM (MODE_NUM)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .kbus  (bus)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Reference model: the debounced level follows the sampled key once the sampled value
   // has differed from it for CNT_MAX+1 consecutive edges; outputs follow two edges later.
   bit exp_flag  = 1'b0;
   bit exp_state = 1'b1;
   int exp_mode  = 0;
   bit deb       = 1'b1;
   bit prev      = 1'b1;
   int run       = 0;
   bit d1_press, d1_rel, d2_press, d2_rel;

   int flag_count     = 0;
   int last_flag_cyc  = -1;
   int last_rise_cyc  = -1;
   bit seen_state     = 1'b1;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at edge %0d", name, act, req, cyc);
      end
   endtask

   always @(posedge clk) begin
      bit v;
      cyc++;
      if (!rst_n) begin
         exp_flag = 1'b0;
         exp_state = 1'b1;
         exp_mode = 0;
         deb = 1'b1;
         prev = 1'b1;
         run = 0;
         d1_press = 1'b0; d1_rel = 1'b0; d2_press = 1'b0; d2_rel = 1'b0;
      end else begin
         exp_flag = d2_press;
         if (d2_press) begin
            exp_state = 1'b0;
            exp_mode  = (exp_mode + 1) % MODE_NUM;
         end
         if (d2_rel) exp_state = 1'b1;
         d2_press = d1_press;
         d2_rel   = d1_rel;
         d1_press = 1'b0;
         d1_rel   = 1'b0;
         v = bus.key_in;
         run = (v == prev) ? run + 1 : 1;
         prev = v;
         if (v != deb && run == CNT_MAX + 1) begin
            deb = v;
            if (!v) d1_press = 1'b1;
            else    d1_rel   = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (cyc > 0) begin
         chk("key_flag",  int'(bus.key_flag),  int'(exp_flag));
         chk("key_state", int'(bus.key_state), int'(exp_state));
         chk("mode",      int'(bus.mode),      exp_mode);
         if (bus.key_flag === 1'b1) begin
            flag_count++;
            last_flag_cyc = cyc;
         end
         if (bus.key_state === 1'b1 && !seen_state) last_rise_cyc = cyc;
         seen_state = (bus.key_state === 1'b1);
      end
   end

   task automatic hold(input logic v, input int n);
      bus.key_in = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      hold(1'b1, n);
      rst_n = 1'b1;
      hold(1'b1, 5);
      #2;
   endtask

   initial begin
      int start, fc;
      int mode_seq [5];
      int want_seq [5];
      want_seq = '{1, 2, 3, 0, 1};
      bus.key_in = 1'b1;
      rst_n = 1'b0;

      // Reset state
      do_reset(3);
      chk("reset_flag",  int'(bus.key_flag),  0);
      chk("reset_state", int'(bus.key_state), 1);
      chk("reset_mode",  int'(bus.mode),      0);

      // Clean press then clean release
      fc = flag_count; start = cyc;
      hold(1'b0, 20); #2;
      chk("clean_flag_count", flag_count - fc, 1);
      chk("clean_flag_edge",  last_flag_cyc - start, 13);
      chk("clean_state",      int'(bus.key_state), 0);
      chk("clean_mode",       int'(bus.mode), 1);
      start = cyc;
      hold(1'b1, 20); #2;
      chk("clean_release_edge", last_rise_cyc - start, 13);

      // Press bounce
      fc = flag_count;
      hold(1'b0, 4);
      hold(1'b1, 3);
      start = cyc;
      hold(1'b0, 20); #2;
      chk("bounce_flag_count", flag_count - fc, 1);
      chk("bounce_flag_edge",  last_flag_cyc - start, 13);
      chk("bounce_mode",       int'(bus.mode), 2);

      // Release bounce from DOWN
      fc = flag_count;
      hold(1'b1, 5);
      hold(1'b0, 5); #2;
      chk("rel_bounce_state", int'(bus.key_state), 0);
      chk("rel_bounce_flags", flag_count - fc, 0);
      start = cyc;
      hold(1'b1, 20); #2;
      chk("rel_bounce_edge", last_rise_cyc - start, 13);

      // Mode wrap over five presses
      do_reset(2);
      fc = flag_count;
      for (int i = 0; i < 5; i++) begin
         hold(1'b0, 16); #2;
         mode_seq[i] = int'(bus.mode);
         hold(1'b1, 16); #2;
      end
      for (int i = 0; i < 5; i++) chk($sformatf("wrap_mode_%0d", i), mode_seq[i], want_seq[i]);
      chk("wrap_flag_count", flag_count - fc, 5);

      // Reset mid-filter at cnt=5 with the key held low
      do_reset(2);
      fc = flag_count;
      hold(1'b0, 8);
      rst_n = 1'b0;
      hold(1'b0, 1);
      rst_n = 1'b1;
      start = cyc;
      hold(1'b0, 10); #2;
      chk("midrst_mode_hold", int'(bus.mode), 0);
      chk("midrst_no_flag",   flag_count - fc, 0);
      hold(1'b0, 10); #2;
      chk("midrst_flag_edge", last_flag_cyc - start, 13);
      chk("midrst_mode_step", int'(bus.mode), 1);
      hold(1'b1, 20);

      // Random bouncing keys with occasional reset pulses
      for (int s = 0; s < 250; s++) begin
         if ($urandom_range(0, 39) == 0) begin
            rst_n = 1'b0;
            hold(1'($urandom_range(0, 1)), $urandom_range(1, 2));
            rst_n = 1'b1;
         end else if ($urandom_range(0, 3) == 0) begin
            hold(1'($urandom_range(0, 1)), $urandom_range(CNT_MAX, CNT_MAX + 15));
         end else begin
            hold(1'($urandom_range(0, 1)), $urandom_range(1, CNT_MAX + 2));
         end
      end
      hold(1'b1, 30);
      #2;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/key_mode_sel.md
KEY_MODE_SEL -- requirements
Module: key_mode_sel

Interface
REQ-001 Parameter CNT_MAX, default 1_000_000, debounce window in clk cycles (20 ms at 50 MHz); legal range >= 2.
REQ-002 Parameter MODE_NUM, default 4, number of LED display modes; legal range 2..4.
REQ-003 clk  input  1  system clock; single clock domain; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; synchronous; active-low.
REQ-005 key_in  input  1  raw push-button; asynchronous to clk; active-low (pressed = 0); may bounce.
REQ-006 key_flag  output  1  one-cycle pulse on each debounced press.
REQ-007 key_state  output  1  debounced key level; 1 = released, 0 = pressed.
REQ-008 mode  output  2  current LED mode index, 0..MODE_NUM-1; drives the mode select of the downstream LED driver.

Function
REQ-009 key_in SHALL pass through a 2-flop synchronizer (k1, k2), followed by a delay flop k3.
REQ-010 neg_edge = k3 & ~k2 and pos_edge = ~k3 & k2, combinational.
REQ-011 The FSM SHALL have exactly four states: IDLE, FILTER_DOWN, DOWN, FILTER_UP.
REQ-012 IDLE: on neg_edge, go to FILTER_DOWN and clear cnt to 0; otherwise hold.
REQ-013 FILTER_DOWN: cnt increments by 1 per cycle.
  - pos_edge before cnt reaches CNT_MAX-1: return to IDLE, clear cnt, no key_flag.
  - cnt == CNT_MAX-1 (no pos_edge): go to DOWN, clear cnt, register key_flag=1 and key_state=0.
REQ-014 DOWN: on pos_edge, go to FILTER_UP and clear cnt; otherwise hold.
REQ-015 FILTER_UP: cnt increments by 1 per cycle.
  - neg_edge before cnt reaches CNT_MAX-1: return to DOWN, clear cnt.
  - cnt == CNT_MAX-1: go to IDLE, clear cnt, register key_state=1.
  - key_flag is never asserted on release.
REQ-016 pos_edge and cnt == CNT_MAX-1 in the same FILTER_DOWN cycle: pos_edge wins (IDLE, no flag).
  - Mirror rule in FILTER_UP: neg_edge wins (DOWN).
REQ-017 key_flag SHALL be high for exactly one clk cycle per confirmed press and low in all other cycles.
REQ-018 Latency, bounce-free press: count the first rising edge that samples key_in=0 as edge 1; key_flag goes high after edge CNT_MAX+3 and low after edge CNT_MAX+4.
REQ-019 Release latency: key_state returns to 1 after edge CNT_MAX+3 counted from the first edge sampling key_in=1.
REQ-020 mode SHALL increment in the same cycle key_flag is registered; at MODE_NUM-1 it wraps to 0.
  - mode changes on no other event.
REQ-021 cnt SHALL be sized to hold CNT_MAX-1; it never exceeds CNT_MAX-1 and never wraps.
REQ-022 Holding the key pressed indefinitely SHALL produce exactly one key_flag and one mode step.

Reset
REQ-023 While rst_n=0 at a clk edge, the block resets to: state=IDLE, cnt=0, k1=k2=k3=1, key_flag=0, key_state=1, mode=0.
REQ-024 Reset asserted in any state, including mid-filter, SHALL abort the operation with no key_flag and no mode change; reset dominates all other events.
REQ-025 After rst_n rises with key_in held 0, a press SHALL be detected normally, since the synchronizer reset value 1 yields a neg_edge.

Verification (CNT_MAX=10, MODE_NUM=4, clk 20 ns)
REQ-026 Clean press: key_in 1->0 sampled at edge 1 and held -> key_flag high only between edges 13 and 14; key_state=0 and mode=1 from edge 13.
REQ-027 Bounce: key_in low 4 cycles, high 3, then low and held -> exactly one key_flag, CNT_MAX+3 edges after the final falling edge.
REQ-028 Release bounce: from DOWN, key_in high 5 cycles then low -> key_state stays 0 and no key_flag; then high and held -> key_state=1 at edge 13 of that release.
REQ-029 Wrap: 5 clean press/release cycles -> mode sequence 1,2,3,0,1; exactly 5 key_flag pulses.
REQ-030 Reset mid-filter: rst_n=0 for 1 cycle while in FILTER_DOWN at cnt=5, key_in held 0 -> key_flag stays 0 until a new full window; mode stays 0, then becomes 1.
